context_bit_regfile: RTL and testbench
======================================

Name: context_bit_regfile

Overview:
- Per-context bit-cost register file for the CABAC rate estimator in the RDOQ datapath.
- Holds one 16-bit fractional-bit cost per context per bin value (0/1).
- Initialised to table values on reset; updated by the probability/cost update stage; read combinationally by the rate calculation.

Parameters:
- NUM_CTX, 8, number of contexts stored; legal range 1..32 (read address is 5 bits).
- CTX_TYPE, 0, selects the reset initialisation table (syntax-element class); legal 0..1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- ctx_addr  in  8  write context index
- bin_val  in  1  write target: 0 = bin0 cost, 1 = bin1 cost
- bit_cost_in  in  16  cost to write, unsigned Q4.12 bits
- read_ctx_addr  in  5  read context index
- read_bin_sel  in  1  selects bin for bit_cost_out
- bit_cost_out  out  16  cost of (read_ctx_addr, read_bin_sel)
- bit_cost_out0  out  16  bin0 cost of read_ctx_addr
- bit_cost_out1  out  16  bin1 cost of read_ctx_addr

Behaviour:
- Storage: two arrays, cost0[NUM_CTX] and cost1[NUM_CTX], 16 bits each; unsigned Q4.12, so 16'h1000 = 1.0 bit.
- Reset: rst_n low asynchronously loads every entry from init_cost(CTX_TYPE, ctx, bin).
  - The load holds while rst_n is low.
  - A reset asserted mid-operation discards all written values.
- Init table, CTX_TYPE 0: every ctx has bin0 = bin1 = 16'h1000 (equiprobable, HM init value 154).
- Init table, CTX_TYPE 1: bin0 = 16'h0800, bin1 = 16'h1C00 for every ctx.
- Write: on posedge clk with rst_n high and we = 1:
  - if ctx_addr < NUM_CTX, write bit_cost_in to cost1[ctx_addr] when bin_val = 1, else to cost0[ctx_addr];
  - the other bin of that context is untouched.
  - The compare uses the full 8-bit ctx_addr, so ctx_addr >= NUM_CTX is silently ignored and no entry changes.
- One write per cycle; back-to-back writes on consecutive cycles are all applied.
- Read: purely combinational, zero latency.
  - bit_cost_out0 = cost0[read_ctx_addr]
  - bit_cost_out1 = cost1[read_ctx_addr]
  - bit_cost_out = read_bin_sel ? out1 : out0
- Out-of-range read: read_ctx_addr >= NUM_CTX forces all three outputs to 16'h0000.
- Same-address read and write: the outputs show the old value until the clock edge and the new value immediately after it. There is no write-to-read bypass before the edge.
- During reset the outputs reflect the init values (or 0 for an out-of-range address).
- No saturation or arithmetic in this block; the value is stored verbatim.

Decomposition:
- Package cabac_rate_pkg holds:
  - COST_W = 16 and COST_FRAC = 12;
  - typedef cost_t;
  - COST_ONE_BIT = 16'h1000;
  - function init_cost(ctx_type, ctx_idx, bin) returning cost_t, shared with other context tables.
- No sub-module is needed. The init table is a package function, and the storage is two flop arrays in this module.

Test Plan:
- Reset release, CTX_TYPE 0, read ctx 2 bin 1 -> bit_cost_out = 16'h1000; out0 = out1 = 16'h1000.
- Read ctx 31 -> all outputs 16'h0000. Write we=1, ctx_addr=100, bin 1, 16'hDEAD -> ctx 3 bin 1 still 16'h1000, and no entry holds DEAD.
- Back-to-back writes ctx 1: bin0 16'h1111, then bin1 16'h2222 on the next cycle -> ctx 1 bin0 = 1111, bin1 = 2222.
- Write ctx 4 bin0 16'hAAAA -> out0 = AAAA, out1 = 16'h1000 (bin isolation).
- Read ctx 5 bin 1 while writing ctx 5 bin 1 16'hFACE -> old 16'h1000 before the edge, FACE after it.
- Write ctx 6 bin 1 16'hBEEF, then pulse rst_n low 10 ns asynchronously -> ctx 6 bin 1 = 16'h1000. Repeat reset with CTX_TYPE 1 -> bin0 0800, bin1 1C00.

Source files
------------

// File: rtl/cabac_rate_pkg.sv
// Shared definitions for the CABAC rate estimator: cost format and the
// reset initialisation tables used by the per-context cost register files.
package cabac_rate_pkg;

  localparam int COST_W    = 16;
  localparam int COST_FRAC = 12;

  // Unsigned Q4.12 fractional-bit cost.
  typedef logic [COST_W-1:0] cost_t;

  localparam cost_t COST_ONE_BIT = 16'h1000;

  typedef enum logic [0:0] {
    CTX_TYPE_EQUIPROB = 1'b0,
    CTX_TYPE_SKEWED   = 1'b1
  } ctx_type_e;

  // Reset cost for (table class, context, bin). Contexts beyond the 5-bit
  // read address space have no table entry and return zero.
  function automatic cost_t init_cost(input int ctx_type, input int ctx_idx, input logic bin);
    cost_t c;
    c = COST_ONE_BIT;
    if (ctx_type == int'(CTX_TYPE_SKEWED)) begin
      c = bin ? 16'h1C00 : 16'h0800;
    end
    if (ctx_idx < 0 || ctx_idx > 31) begin
      c = '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/context_bit_regfile.sv
// Per-context bin0/bin1 bit-cost storage for the RDOQ rate estimator.
// Entries load from the init table while reset is low, take one write per
// clock from the cost update stage, and are read combinationally.
module context_bit_regfile
  import cabac_rate_pkg::*;
#(
  parameter int NUM_CTX  = 8,
  parameter int CTX_TYPE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [7:0]  ctx_addr,
  input  logic        bin_val,
  input  logic [15:0] bit_cost_in,
  input  logic [4:0]  read_ctx_addr,
  input  logic        read_bin_sel,
  output logic [15:0] bit_cost_out,
  output logic [15:0] bit_cost_out0,
  output logic [15:0] bit_cost_out1
);

  // Write interface: we is a single-cycle strobe with no backpressure; every
  // rising edge with we high commits exactly one write, so back-to-back
  // strobes are all applied. An address outside 0..NUM_CTX-1 (full 8-bit
  // compare) is dropped without touching any entry.

  cost_t cost0 [NUM_CTX];
  cost_t cost1 [NUM_CTX];

  // Table load while in reset; otherwise commit the strobed write to one bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        cost0[i] <= init_cost(CTX_TYPE, i, 1'b0);
        cost1[i] <= init_cost(CTX_TYPE, i, 1'b1);
      end
    end else if (we) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (int'(ctx_addr) == i) begin
          if (bin_val) begin
            cost1[i] <= bit_cost_in;
          end else begin
            cost0[i] <= bit_cost_in;
          end
        end
      end
    end
  end

  // Zero-latency read; an address with no stored context reads as zero.
  always_comb begin
    bit_cost_out0 = '0;
    bit_cost_out1 = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (int'(read_ctx_addr) == i) begin
        bit_cost_out0 = cost0[i];
        bit_cost_out1 = cost1[i];
      end
    end
    bit_cost_out = read_bin_sel ? bit_cost_out1 : bit_cost_out0;
  end

endmodule

// File: tb/tb_context_bit_regfile.sv
// Bench for context_bit_regfile: one instance per init table class, shared
// stimulus, compared against an array model of the cost tables.
module tb_context_bit_regfile;

  localparam int NUM_CTX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        we;
  logic [7:0]  ctx_addr;
  logic        bin_val;
  logic [15:0] bit_cost_in;
  logic [4:0]  read_ctx_addr;
  logic        read_bin_sel;
  logic [15:0] out_t0, out0_t0, out1_t0;
  logic [15:0] out_t1, out0_t1, out1_t1;

  context_bit_regfile #(.NUM_CTX(NUM_CTX), .CTX_TYPE(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .we(we), .ctx_addr(ctx_addr), .bin_val(bin_val),
    .bit_cost_in(bit_cost_in), .read_ctx_addr(read_ctx_addr), .read_bin_sel(read_bin_sel),
    .bit_cost_out(out_t0), .bit_cost_out0(out0_t0), .bit_cost_out1(out1_t0)
  );

  context_bit_regfile #(.NUM_CTX(NUM_CTX), .CTX_TYPE(1)) dut_t1 (
    .clk(clk), .rst_n(rst_n), .we(we), .ctx_addr(ctx_addr), .bin_val(bin_val),
    .bit_cost_in(bit_cost_in), .read_ctx_addr(read_ctx_addr), .read_bin_sel(read_bin_sel),
    .bit_cost_out(out_t1), .bit_cost_out0(out0_t1), .bit_cost_out1(out1_t1)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_cost [2][2][NUM_CTX];  // [table class][bin][ctx]

  function automatic logic [15:0] spec_init(input int t, input int b);
    if (t == 0) return 16'h1000;
    return (b != 0) ? 16'h1C00 : 16'h0800;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 2; t++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < NUM_CTX; c++)
          m_cost[t][b][c] = spec_init(t, b);
  endtask

  task automatic model_write(input int c, input int b, input logic [15:0] v);
    if (c < NUM_CTX)
      for (int t = 0; t < 2; t++) m_cost[t][b][c] = v;
  endtask

  function automatic logic [15:0] model_read(input int t, input int c, input int b);
    if (c >= NUM_CTX) return 16'h0000;
    return m_cost[t][b][c];
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (rd_ctx=%0d sel=%0d t=%0t)",
               tag, got, exp, read_ctx_addr, read_bin_sel, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int rc;
    int sel;
    rc  = int'(read_ctx_addr);
    sel = int'(read_bin_sel);
    for (int t = 0; t < 2; t++) begin
      exp_q.push_back(model_read(t, rc, 0));
      exp_q.push_back(model_read(t, rc, 1));
      exp_q.push_back(model_read(t, rc, sel));
    end
    check({tag, "/t0.out0"}, out0_t0, exp_q.pop_front());
    check({tag, "/t0.out1"}, out1_t0, exp_q.pop_front());
    check({tag, "/t0.out"},  out_t0,  exp_q.pop_front());
    check({tag, "/t1.out0"}, out0_t1, exp_q.pop_front());
    check({tag, "/t1.out1"}, out1_t1, exp_q.pop_front());
    check({tag, "/t1.out"},  out_t1,  exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_read(input int c, input int b);
    read_ctx_addr = c[4:0];
    read_bin_sel  = b[0];
    #1;
  endtask

  task automatic do_write(input int c, input int b, input logic [15:0] v);
    we          = 1'b1;
    ctx_addr    = c[7:0];
    bin_val     = b[0];
    bit_cost_in = v;
    @(posedge clk);
    model_write(c, b, v);
    #1;
    we = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < NUM_CTX; c++)
      for (int b = 0; b < 2; b++) begin
        set_read(c, b);
        check_outputs(tag);
      end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("in_reset");
    #9;
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; we = 1'b0; ctx_addr = '0; bin_val = 1'b0;
    bit_cost_in = '0; read_ctx_addr = 5'd2; read_bin_sel = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release values
    set_read(2, 1);
    check_outputs("init_ctx2");

    // Out-of-range read
    set_read(31, 0);
    check_outputs("oor_read31");

    // Out-of-range write is ignored everywhere
    do_write(100, 1, 16'hDEAD);
    set_read(3, 1);
    check_outputs("oor_write_ctx3");
    sweep("oor_write_sweep");

    // Back-to-back writes to ctx 1
    we = 1'b1; ctx_addr = 8'd1; bin_val = 1'b0; bit_cost_in = 16'h1111;
    @(posedge clk);
    model_write(1, 0, 16'h1111);
    #1;
    bin_val = 1'b1; bit_cost_in = 16'h2222;
    @(posedge clk);
    model_write(1, 1, 16'h2222);
    #1;
    we = 1'b0;
    set_read(1, 0);
    check_outputs("b2b_ctx1");

    // Bin isolation
    do_write(4, 0, 16'hAAAA);
    set_read(4, 0);
    check_outputs("bin_iso_ctx4");

    // Same-address read during write: old before edge, new after
    set_read(5, 1);
    we = 1'b1; ctx_addr = 8'd5; bin_val = 1'b1; bit_cost_in = 16'hFACE;
    #1;
    check_outputs("raw_before_edge");
    @(posedge clk);
    model_write(5, 1, 16'hFACE);
    #1;
    we = 1'b0;
    check_outputs("raw_after_edge");

    // Reset mid-operation discards writes
    do_write(6, 1, 16'hBEEF);
    set_read(6, 1);
    check_outputs("pre_reset_ctx6");
    reset_pulse();
    set_read(6, 1);
    check_outputs("post_reset_ctx6");
    sweep("post_reset_sweep");

    // Randomised traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      int wc;
      int rc;
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse();
      end
      wc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      rc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      we          = ($urandom_range(0, 3) != 0);
      ctx_addr    = wc[7:0];
      bin_val     = 1'($urandom_range(0, 1));
      bit_cost_in = 16'($urandom());
      read_ctx_addr = rc[4:0];
      read_bin_sel  = 1'($urandom_range(0, 1));
      #1;
      check_outputs("rand_pre_edge");
      @(posedge clk);
      if (we) model_write(int'(ctx_addr), int'(bin_val), bit_cost_in);
      #1;
      we = 1'b0;
    end
    sweep("final_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
